// File: rtl/mx_pkg.sv
// Shared types and constants for the bf16 -> MXINT8 block path.
// Used by bf16_block_packer, bf16_block_buf and the downstream converter.
package mx_pkg;

    localparam int unsigned BF16_W   = 16;
    localparam int unsigned MX_BLOCK = 32;
    localparam int unsigned IDX_W    = $clog2(MX_BLOCK);   // element index within a block
    localparam int unsigned NV_W     = IDX_W + 1;          // element count 0..MX_BLOCK

    typedef logic [BF16_W-1:0] bf16_t;
    typedef bf16_t bf16_blk_t [MX_BLOCK];

endpackage

// File: rtl/bf16_block_buf.sv
// One 32-element bf16 block buffer with its full flag.
// Optional MX_PACK_FLUSH_EN: an early close zero-pads the unwritten tail and
// records the real element count.
module bf16_block_buf
    import mx_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_base,
    input  bf16_t            wr_data [LANES],
    input  logic             close,
`ifdef MX_PACK_FLUSH_EN
    input  logic [NV_W-1:0]  close_count,
    output logic [NV_W-1:0]  nvalid,
`endif
    input  logic             retire,
    output logic             full,
    output bf16_blk_t        data
);

    // Block storage: tail pad on an early close, then the beat's lane writes
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data <= '{default: '0};
        end else begin
`ifdef MX_PACK_FLUSH_EN
            if (close) begin
                for (int unsigned e = 0; e < MX_BLOCK; e++) begin
                    if (NV_W'(e) >= close_count) data[e] <= '0;
                end
            end
`endif
            if (wr_en) begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    data[wr_base + IDX_W'(l)] <= wr_data[l];
                end
            end
        end
    end

    // Full flag: set by the closing beat, cleared when downstream retires the block
    always_ff @(posedge i_clk) begin
        if (i_rst)       full <= 1'b0;
        else if (close)  full <= 1'b1;
        else if (retire) full <= 1'b0;
    end

`ifdef MX_PACK_FLUSH_EN
    // Real (non-pad) element count, captured with the closing beat
    always_ff @(posedge i_clk) begin
        if (i_rst)      nvalid <= '0;
        else if (close) nvalid <= close_count;
    end
`endif

endmodule

// File: rtl/bf16_block_packer.sv
// Packs a LANES-wide bf16 valid/ready stream into 32-element blocks using two
// ping-pong buffers, so input keeps streaming while a block waits downstream.
// Optional MX_PACK_FLUSH_EN: i_last closes a block early (zero-padded), o_nvalid
// reports the real element count.
module bf16_block_packer
    import mx_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  bf16_t           i_bf16 [LANES],
`ifdef MX_PACK_FLUSH_EN
    input  logic            i_last,
`endif
    output logic            o_valid,
    input  logic            i_ready,
    output bf16_blk_t       o_bf16_vec
`ifdef MX_PACK_FLUSH_EN
    ,
    output logic [NV_W-1:0] o_nvalid
`endif
);

    localparam int unsigned NBEATS = MX_BLOCK / LANES;
    localparam int unsigned BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    if ((MX_BLOCK % LANES) != 0) begin : g_lanes_check
        $error("bf16_block_packer: LANES must divide MX_BLOCK");
    end

    logic              wr_sel;
    logic              rd_sel;
    logic [BEAT_W-1:0] beat_idx;
    logic              accept;
    logic              close;
    logic              retire;
    logic [IDX_W-1:0]  wr_base;
    logic              full     [2];
    bf16_blk_t         buf_data [2];
`ifdef MX_PACK_FLUSH_EN
    logic [NV_W-1:0]   close_count;
    logic [NV_W-1:0]   buf_nvalid [2];
`endif

    // Handshakes, block-close decision and output selection
    always_comb begin
        accept     = i_valid && o_ready;
        retire     = o_valid && i_ready;
        wr_base    = IDX_W'(32'(beat_idx) * LANES);
`ifdef MX_PACK_FLUSH_EN
        close       = accept && ((beat_idx == BEAT_W'(NBEATS - 1)) || i_last);
        close_count = NV_W'(wr_base) + NV_W'(LANES);
        o_nvalid    = buf_nvalid[rd_sel];
`else
        close      = accept && (beat_idx == BEAT_W'(NBEATS - 1));
`endif
        o_ready    = !full[wr_sel];
        o_valid    = full[rd_sel];
        o_bf16_vec = buf_data[rd_sel];
    end

    // Write/read pointers and beat position within the block being filled
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_sel   <= 1'b0;
            rd_sel   <= 1'b0;
            beat_idx <= '0;
        end else begin
            if (accept) begin
                if (close) begin
                    wr_sel   <= ~wr_sel;
                    beat_idx <= '0;
                end else begin
                    beat_idx <= beat_idx + BEAT_W'(1);
                end
            end
            if (retire) rd_sel <= ~rd_sel;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_buf
        bf16_block_buf #(
            .LANES(LANES)
        ) u_buf (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .wr_en       (accept && (wr_sel == 1'(b))),
            .wr_base     (wr_base),
            .wr_data     (i_bf16),
            .close       (close && (wr_sel == 1'(b))),
`ifdef MX_PACK_FLUSH_EN
            .close_count (close_count),
            .nvalid      (buf_nvalid[b]),
`endif
            .retire      (retire && (rd_sel == 1'(b))),
            .full        (full[b]),
            .data        (buf_data[b])
        );
    end

endmodule
